// File: rtl/rv_defs_pkg.sv
// rv_defs_pkg: shared RV32I load/store definitions.
//   - funct3 width codes for loads and stores
//   - FSM state encoding for the load/store unit
//   - width_ok(): legality of a funct3 code for a load or a store
package rv_defs_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    function automatic logic width_ok(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane formatting for the load/store unit.
// Ports:
//   funct3     in  3   access width code
//   offset     in  2   byte address bits [1:0]
//   wdata      in  32  LSB-aligned store data
//   be         out 4   byte enables for the access
//   wdata_lane out 32  store data replicated across lanes
//   rdata      in  32  bus read word
//   rdata_ext  out 32  selected lane, sign/zero extended
// Halfwords use offset[1] only and words ignore the offset, so low
// address bits that are not trapped upstream are silently dropped here.
module lsu_align
    import rv_defs_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    input  logic [31:0] rdata,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        be         = '0;
        wdata_lane = wdata;
        case (funct3[1:0])
            2'b00: begin
                be         = 4'b0001 << offset;
                wdata_lane = {4{wdata[7:0]}};
            end
            2'b01: begin
                be         = offset[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
            end
            2'b10:   be = '1;
            default: be = '0;
        endcase
    end

    always_comb begin
        case (offset)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        case (funct3)
            F3_B:    rdata_ext = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   rdata_ext = {24'd0, byte_sel};
            F3_H:    rdata_ext = {{16{half_sel[15]}}, half_sel};
            F3_HU:   rdata_ext = {16'd0, half_sel};
            F3_W:    rdata_ext = rdata;
            default: rdata_ext = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store unit bridging a stalling core to a
// request/grant/response memory bus.
// Parameter: TIMEOUT_CYCLES - max cycles spent in REQ+WAIT before abort.
// Build option: MISALIGN_TRAP_EN - when defined, misaligned halfword/word
//   accesses fault without a bus transaction; otherwise low bits are dropped.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/we/funct3/addr/wdata  core request (held while stall=1)
//   stall                           freeze core (combinational)
//   load_data, load_valid, err      completion result and pulses
//   mem_req/we/addr/be/wdata        bus request (driven only in REQ)
//   mem_gnt, mem_rvalid, mem_rdata  bus grant and response
module load_store_unit
    import rv_defs_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state, nxt;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_fault;
    logic [15:0] cnt;

    logic        misaligned, req_ok, resp, timeout;
    logic [3:0]  be;
    logic [31:0] wdata_lane, rdata_ext;

`ifdef MISALIGN_TRAP_EN
    assign misaligned = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                        (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign req_ok = width_ok(req_we, req_funct3) && !misaligned;

    // A response counts in REQ only together with its grant.
    assign resp    = (state == REQ && mem_gnt && mem_rvalid) ||
                     (state == WAIT && mem_rvalid);
    assign timeout = (state == REQ || state == WAIT) &&
                     cnt == 16'(TIMEOUT_CYCLES - 1);

    lsu_align u_align (
        .funct3     (r_f3),
        .offset     (r_addr[1:0]),
        .wdata      (r_wdata),
        .be         (be),
        .wdata_lane (wdata_lane),
        .rdata      (mem_rdata),
        .rdata_ext  (rdata_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE: if (req_valid) nxt = req_ok ? REQ : DONE;
            REQ: begin
                if (resp || timeout) nxt = DONE;
                else if (mem_gnt)    nxt = WAIT;
            end
            WAIT: if (resp || timeout) nxt = DONE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        stall      = req_valid && (state != DONE);
        load_valid = (state == DONE);
        err        = (state == DONE) && r_fault;
        mem_req    = (state == REQ);
        mem_we     = (state == REQ) && r_we;
        mem_addr   = (state == REQ) ? {r_addr[31:2], 2'b00} : '0;
        mem_be     = (state == REQ) ? be : '0;
        mem_wdata  = (state == REQ && r_we) ? wdata_lane : '0;
    end

    // Request capture, timeout counter and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we      <= 1'b0;
            r_f3      <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_fault   <= 1'b0;
            cnt       <= '0;
            load_data <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    r_we    <= req_we;
                    r_f3    <= req_funct3;
                    r_addr  <= req_addr;
                    r_wdata <= req_wdata;
                    r_fault <= !req_ok;
                    cnt     <= '0;
                    if (!req_ok) load_data <= '0;
                end
                REQ, WAIT: begin
                    cnt <= cnt + 16'd1;
                    if (resp) begin
                        if (!r_we) load_data <= rdata_ext;
                    end else if (timeout) begin
                        r_fault   <= 1'b1;
                        load_data <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        stall, load_valid, err;
    logic [31:0] load_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    logic [31:0] exp_ld = '0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .load_data(load_data), .load_valid(load_valid), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit legal(input logic we, input logic [2:0] f3, input logic [31:0] a);
        bit ok;
        if (we) ok = (f3 <= 3'd2);
        else    ok = (f3 <= 3'd2) || f3 == 3'd4 || f3 == 3'd5;
`ifdef MISALIGN_TRAP_EN
        if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) ok = 0;
        if (f3 == 3'd2 && (a % 4) != 0) ok = 0;
`endif
        return ok;
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
        int unsigned b, h;
        b = (rd >> (8 * (a % 4))) % 256;
        h = (rd >> (16 * ((a / 2) % 2))) % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? 32'(b) + 32'hFFFFFF00 : 32'(b);
            3'd4:    return 32'(b);
            3'd1:    return (h >= 32768) ? 32'(h) + 32'hFFFF0000 : 32'(h);
            3'd5:    return 32'(h);
            default: return rd;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'd0) return 4'(1 << (a % 4));
        if (f3 == 3'd1) return ((a / 2) % 2 == 1) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        if (f3 == 3'd0) return (wd % 256) * 32'h01010101;
        if (f3 == 3'd1) return (wd % 65536) * 32'h00010001;
        return wd;
    endfunction

    // One transaction: grant at REQ-cycle index g, response at index r (r >= g).
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int g, input int r, input bit drop);
        bit ok, to;
        int done_k, idx;
        ok = legal(we, f3, a);
        to = ok && (r > T - 1);
        done_k = !ok ? 1 : (to ? T + 1 : r + 2);

        @(posedge clk); #1;
        req_valid = 1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        mem_gnt = 0; mem_rvalid = 0;
        #1;
        check("c0_stall", 32'(stall), 32'd1);
        check("c0_mem_req", 32'(mem_req), 32'd0);

        for (int k = 1; k <= done_k; k++) begin
            @(posedge clk); #1;
            idx = k - 1;
            if (drop) req_valid = 1'($urandom_range(1));
            if (k == done_k) begin
                mem_gnt = 0; mem_rvalid = 1'($urandom_range(1)); mem_rdata = $urandom;
            end else begin
                mem_gnt = (idx == g); mem_rvalid = (idx == r);
                mem_rdata = (idx == r) ? rd : $urandom;
            end
            #1;
            if (k < done_k) begin
                check("busy_mem_req", 32'(mem_req), 32'(idx <= g));
                if (idx <= g) begin
                    check("mem_addr", mem_addr, a & 32'hFFFFFFFC);
                    check("mem_we", 32'(mem_we), 32'(we));
                    if (we) begin
                        check("mem_be", 32'(mem_be), 32'(store_be(f3, a)));
                        check("mem_wdata", mem_wdata, store_data(f3, wd));
                    end
                end
                check("busy_load_valid", 32'(load_valid), 32'd0);
                check("busy_err", 32'(err), 32'd0);
                check("busy_stall", 32'(stall), 32'(req_valid));
            end else begin
                if (!ok || to) exp_ld = '0;
                else if (!we) exp_ld = load_ext(f3, a, rd);
                check("done_load_valid", 32'(load_valid), 32'd1);
                check("done_err", 32'(err), 32'(!ok || to));
                check("done_load_data", load_data, exp_ld);
                check("done_stall", 32'(stall), 32'd0);
                check("done_mem_req", 32'(mem_req), 32'd0);
            end
        end

        @(posedge clk); #1;
        req_valid = 0; mem_gnt = 0; mem_rvalid = 1'($urandom_range(1));
        #1;
        check("idle_load_valid", 32'(load_valid), 32'd0);
        check("idle_err", 32'(err), 32'd0);
        check("idle_load_data_hold", load_data, exp_ld);
        check("idle_mem_req", 32'(mem_req), 32'd0);
    endtask

    // Reset in REQ (inreq=1) or WAIT: abandon with no completion.
    task automatic reset_mid(input bit inreq);
        @(posedge clk); #1;
        req_valid = 1; req_we = 0; req_funct3 = 3'd2; req_addr = 32'h100;
        mem_gnt = 0; mem_rvalid = 0;
        @(posedge clk); #1;
        mem_gnt = !inreq;
        #1;
        check("rst_pre_mem_req", 32'(mem_req), 32'd1);
        if (!inreq) begin
            @(posedge clk); #1;
            mem_gnt = 0;
        end
        rst_n = 0;
        #1;
        exp_ld = '0;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_load_data", load_data, 32'd0);
        check("rst_load_valid", 32'(load_valid), 32'd0);
        req_valid = 0;
        @(posedge clk); #1;
        rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            mem_rvalid = 1; mem_gnt = 1; mem_rdata = 32'h12345678;
            #1;
            check("post_rst_load_valid", 32'(load_valid), 32'd0);
            check("post_rst_mem_req", 32'(mem_req), 32'd0);
        end
        mem_rvalid = 0; mem_gnt = 0;
    endtask

    initial begin
        rst_n = 0; req_valid = 0; req_we = 0; req_funct3 = '0; req_addr = '0;
        req_wdata = '0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
        #12;
        check("reset_mem_req", 32'(mem_req), 32'd0);
        check("reset_load_data", load_data, 32'd0);
        check("reset_load_valid", 32'(load_valid), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_mem_be", 32'(mem_be), 32'd0);
        rst_n = 1;

        run_txn(0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1, 0);
        run_txn(1, 3'd0, 32'h203, 32'h000000A5, 32'h0, 0, 1, 0);
        run_txn(0, 3'd0, 32'h102, 32'h0, 32'h00800000, 0, 1, 0);
        run_txn(0, 3'd4, 32'h102, 32'h0, 32'h00800000, 0, 0, 0);
        run_txn(0, 3'd2, 32'h300, 32'h0, 32'h11111111, 99, 99, 0);
        run_txn(0, 3'd1, 32'h101, 32'h0, 32'hA5A58001, 1, 2, 0);
        run_txn(1, 3'd4, 32'h104, 32'h0, 32'h0, 0, 1, 0);
        run_txn(0, 3'd3, 32'h104, 32'h0, 32'h0, 0, 1, 0);

        for (int n = 0; n < 150; n++) begin
            logic        we;
            logic [2:0]  f3;
            int          g, r;
            we = 1'($urandom_range(1));
            f3 = ($urandom_range(9) == 0) ? 3'($urandom_range(7))
                 : (we ? 3'($urandom_range(2)) : (($urandom_range(1) == 1) ? 3'($urandom_range(2))
                                                 : 3'(4 + $urandom_range(1))));
            g = $urandom_range(T + 1);
            r = g + $urandom_range(3);
            run_txn(we, f3, $urandom, $urandom, $urandom, g, r, 1'($urandom_range(1)));
        end

        reset_mid(0);
        reset_mid(1);
        run_txn(0, 3'd5, 32'h402, 32'h0, 32'h8001_7FFF, 2, 3, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, giving the max cycles spent in REQ+WAIT before abort.
REQ-002 The block SHALL have the following ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  core access request, held while stall=1.
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  RV32I load/store width code.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, LSB-aligned.
- stall  out  1  freeze core (combinational).
- load_data  out  32  extended load value to writeback mem source.
- load_valid  out  1  one-cycle completion pulse.
- err  out  1  one-cycle fault pulse.
- mem_req  out  1  bus request.
- mem_we  out  1  bus write.
- mem_addr  out  32  word address, bits[1:0]=0.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-aligned write data.
- mem_gnt  in  1  bus accepted request.
- mem_rvalid  in  1  bus response; data valid for loads, ack for stores.
- mem_rdata  in  32  read word.

Function
REQ-003 FSM states SHALL be IDLE, REQ, WAIT, DONE.
REQ-004 IDLE with req_valid=1 SHALL capture the request into registers and go to REQ; an invalid width code or enabled misalignment SHALL go straight to DONE with a fault.
REQ-005 REQ SHALL hold mem_req=1 with stable mem_* until mem_gnt=1, then go to WAIT; mem_rvalid in the grant cycle SHALL go directly to DONE.
REQ-006 WAIT SHALL go to DONE on mem_rvalid=1, capturing mem_rdata.
REQ-007 DONE SHALL last one cycle, assert load_valid=1 for loads and stores alike, then return to IDLE.
REQ-008 stall SHALL equal req_valid AND (state != DONE).
REQ-009 The best-case latency, with grant on the first REQ cycle and rvalid one cycle later, SHALL be: req_valid@c0, mem_req@c1, DONE/load_valid@c3.
REQ-010 Stores SHALL be formatted as follows:
- SB (000): byte replicated to all lanes, mem_be=0001<<addr[1:0].
- SH (001): halfword replicated, mem_be=0011 or 1100 by addr[1].
- SW (010): mem_be=1111.
REQ-011 Loads SHALL be extracted as follows:
- LB (000) and LH (001): sign-extended.
- LW (010): full word.
- LBU (100) and LHU (101): zero-extended.
- Lane selected by addr[1:0].
REQ-012 funct3 011/110/111, and any store funct3 other than 000/001/010, SHALL pulse err in DONE with no bus transaction.
REQ-013 A 16-bit counter SHALL run in REQ+WAIT; on reaching TIMEOUT_CYCLES the block SHALL drop mem_req, go to DONE, pulse err, and set load_data=0.
REQ-014 load_data SHALL hold its last value until the next DONE.
REQ-015 Dropping req_valid mid-transaction SHALL NOT abort the bus transaction; the transaction SHALL complete normally.
REQ-016 mem_rvalid arriving in IDLE or DONE SHALL be ignored.

Reset
REQ-017 rst_n=0 SHALL immediately and asynchronously force: state=IDLE, all mem_* outputs=0, load_data=0, load_valid=0, err=0, counter=0.
REQ-018 A reset mid-transaction SHALL abandon the transaction with no completion pulse.

Configuration
REQ-019 With MISALIGN_TRAP_EN defined, halfword accesses with addr[0]=1 and word accesses with addr[1:0]!=0 SHALL pulse err with no bus transaction.
REQ-020 With MISALIGN_TRAP_EN undefined, the block SHALL silently ignore the offending low address bits: SH/LH use addr[1], SW/LW use addr[1:0]=0.

Structure
REQ-021 The shared rv_defs definitions SHALL hold the funct3 width codes and the FSM state encodings.
REQ-022 Lane formatting SHALL be one combinational sub-module, lsu_align: store replicate/byte-enable plus load extract/extend.

Verification
REQ-023 LW at 0x100, gnt@c1, rvalid@c2 with rdata=0xDEADBEEF -> load_data=0xDEADBEEF and load_valid@c3, stall low @c3.
REQ-024 SB at 0x203 with wdata=0x000000A5 -> mem_addr=0x200, mem_be=1000, mem_wdata=0xA5A5A5A5, mem_we=1.
REQ-025 LB at 0x102 with rdata=0x00800000 -> load_data=0xFFFFFF80; LBU at the same address -> load_data=0x00000080.
REQ-026 TIMEOUT_CYCLES=4 with mem_gnt held 0 -> mem_req drops after 4 cycles, err=1 and load_data=0 in DONE.
REQ-027 LH at 0x101: with MISALIGN_TRAP_EN -> err pulse and mem_req never rises; without -> mem_addr=0x100, lane 0 extracted.
REQ-028 rst_n=0 asserted in WAIT -> mem_req=0 immediately, state=IDLE, and no load_valid pulse after reset release.
